// File: rtl/pipe_elastic_stage_pkg.sv
// Shared constants for the elastic pipeline stage and its helpers.
// Every level/flag value used by the stage RTL comes from here, so no
// module carries its own magic numbers.
package pipe_elastic_stage_pkg;

  // Level that asserts the (active-high) reset.
  localparam logic RST_ENABLED   = 1'b1;
  // Level that enables a register or counter update.
  localparam logic WRITE_ENABLED = 1'b1;
  // Level that tells upstream to hold its beat.
  localparam logic STOP          = 1'b0;
  // Entry-valid levels; an invalid entry always carries zero payload.
  localparam logic VALID         = 1'b1;
  localparam logic INVALID       = 1'b0;

endpackage

// File: rtl/pipe_elastic_stage_sat_cnt.sv
// Saturating up-counter used for the stage's performance-debug counters.
// It counts enabled cycles, sticks at all-ones, and is cleared only by reset.
module pipe_sat_cnt
  import pipe_elastic_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on each enabled cycle until the counter reaches all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      count <= '0;
    end else if ((inc == WRITE_ENABLED) && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline-stage register with a valid/ready handshake.
// SKID=1 gives a two-entry (main + skid) buffer with a registered in_ready;
// SKID=0 gives a single entry with a combinational in_ready. Invalid entries
// always hold zeros, so an empty stage presents a bubble with every control
// enable low. Flush kills held and incoming beats at the next edge.
module pipe_elastic_stage
  import pipe_elastic_stage_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      // Upstream may send whenever the skid slot is free; this depends only
      // on a register, so no ready path runs combinationally through here.
      assign in_ready = skid_valid ? STOP : ~STOP;

      // Main/skid update: the skid entry refills main on a drain, otherwise
      // an accepted beat goes to the first free slot in arrival order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
          main_valid <= INVALID;
          main_data  <= '0;
          main_ctrl  <= '0;
          skid_valid <= INVALID;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= INVALID;
          main_data  <= '0;
          main_ctrl  <= '0;
          skid_valid <= INVALID;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else if (drain && skid_valid) begin
          main_valid <= VALID;
          main_data  <= skid_data;
          main_ctrl  <= skid_ctrl;
          skid_valid <= accept;
          skid_data  <= accept ? in_data : '0;
          skid_ctrl  <= accept ? in_ctrl : '0;
        end else if (drain) begin
          main_valid <= accept;
          main_data  <= accept ? in_data : '0;
          main_ctrl  <= accept ? in_ctrl : '0;
        end else if (accept) begin
          if (!main_valid) begin
            main_valid <= VALID;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
          end else begin
            skid_valid <= VALID;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
          end
        end
      end
    end else begin : g_single
      // Single entry: space exists if empty or if the head leaves this cycle.
      assign in_ready  = ~main_valid | out_ready;
      assign skid_valid = INVALID;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;

      // Single-entry update: an accept replaces the entry, a lone drain empties it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
          main_valid <= INVALID;
          main_data  <= '0;
          main_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= INVALID;
          main_data  <= '0;
          main_ctrl  <= '0;
        end else if (accept) begin
          main_valid <= VALID;
          main_data  <= in_data;
          main_ctrl  <= in_ctrl;
        end else if (drain) begin
          main_valid <= INVALID;
          main_data  <= '0;
          main_ctrl  <= '0;
        end
      end
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : '0;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~main_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Testbench for pipe_elastic_stage: one skid instance (SKID=1, 16-bit
// counters) and one single-entry instance (SKID=0, 4-bit counters) share the
// same input stimulus and are compared against a queue-based reference model.
module tb_pipe_elastic_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic [15:0]  in_ctrl;
  logic         flush;
  logic         out_ready;

  logic         s_in_ready, s_out_valid;
  logic [127:0] s_out_data;
  logic [15:0]  s_out_ctrl;
  logic [1:0]   s_occupancy;
  logic [15:0]  s_stall, s_bubble;

  logic         n_in_ready, n_out_valid;
  logic [127:0] n_out_data;
  logic [15:0]  n_out_ctrl;
  logic [1:0]   n_occupancy;
  logic [3:0]   n_stall, n_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each stage is a FIFO of {ctrl,data} with capacity 2
  // (skid) or 1 (single), plus saturating event counts.
  logic [143:0] q0[$];
  logic [143:0] q1[$];
  int stall_m[2];
  int bubble_m[2];
  int cmax[2] = '{65535, 15};

  pipe_elastic_stage #(.DATA_W(128), .CTRL_W(16), .SKID(1'b1), .CNT_W(16)) dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .stall_cnt(s_stall),
    .bubble_cnt(s_bubble)
  );

  pipe_elastic_stage #(.DATA_W(128), .CTRL_W(16), .SKID(1'b0), .CNT_W(4)) dut_single (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .occupancy(n_occupancy), .stall_cnt(n_stall),
    .bubble_cnt(n_bubble)
  );

  logic [179:0] s_obs, n_obs;
  assign s_obs = {s_out_valid, s_in_ready, s_occupancy, s_out_data, s_out_ctrl, s_stall, s_bubble};
  assign n_obs = {n_out_valid, n_in_ready, n_occupancy, n_out_data, n_out_ctrl,
                  12'd0, n_stall, 12'd0, n_bubble};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [143:0] qhead(int k);
    if (qsize(k) == 0) return '0;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic exp_ready(int k);
    if (k == 0) return qsize(0) < 2;
    return (qsize(1) == 0) || out_ready;
  endfunction

  function automatic logic [179:0] exp_vec(int k);
    logic [143:0] h;
    h = qhead(k);
    return {qsize(k) > 0, exp_ready(k), 2'(qsize(k)), h[127:0], h[143:128],
            16'(stall_m[k]), 16'(bubble_m[k])};
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    stall_m  = '{0, 0};
    bubble_m = '{0, 0};
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic rdy, ov, acc, drn;
      rdy = exp_ready(k);
      ov  = qsize(k) > 0;
      acc = in_valid & rdy;
      drn = ov & out_ready;
      if (ov && !out_ready && stall_m[k] < cmax[k]) stall_m[k]++;
      if (!ov && bubble_m[k] < cmax[k]) bubble_m[k]++;
      if (flush) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (drn) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (acc) begin
          if (k == 0) q0.push_back({in_ctrl, in_data}); else q1.push_back({in_ctrl, in_data});
        end
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle by return.
  task automatic applyStimulus(input logic iv, input logic [127:0] d, input logic [15:0] c,
                               input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    advance();
  endtask

  task automatic test_reset();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    applyStimulus(1'b1, a5, 16'h00A5, 1'b0, 1'b1);
    n_checks++; if (s_obs !== {1'b0, 1'b1, 2'd0, 128'd0, 16'd0, 16'd0, 16'd0}) begin n_fail++; $display("[TB] FAIL reset_skid: got %h expected all-zero with in_ready=1", s_obs); end
    n_checks++; if (n_obs !== {1'b0, 1'b1, 2'd0, 128'd0, 16'd0, 16'd0, 16'd0}) begin n_fail++; $display("[TB] FAIL reset_single: got %h expected all-zero with in_ready=1", n_obs); end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if ({s_out_valid, s_occupancy, s_out_data} !== 131'd0) begin n_fail++; $display("[TB] FAIL reset_hold_skid: got %h expected 0", {s_out_valid, s_occupancy, s_out_data}); end
    rst = 1'b0;
    model_reset();
    advance();
    applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
    n_checks++; if ({s_out_valid, s_out_data} !== {1'b1, a5}) begin n_fail++; $display("[TB] FAIL first_accept_skid: got %h expected %h", {s_out_valid, s_out_data}, {1'b1, a5}); end
    n_checks++; if ({n_out_valid, n_out_data} !== {1'b1, a5}) begin n_fail++; $display("[TB] FAIL first_accept_single: got %h expected %h", {n_out_valid, n_out_data}, {1'b1, a5}); end
    advance();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(i < 8, 128'(i), 16'h0100 | 16'(i), 1'b0, 1'b1);
      if (i > 0) begin
        n_checks++; if ({s_out_valid, s_occupancy, s_out_data} !== {1'b1, 2'd1, 128'(i - 1)}) begin n_fail++; $display("[TB] FAIL stream_skid[%0d]: got %h expected %h", i, {s_out_valid, s_occupancy, s_out_data}, {1'b1, 2'd1, 128'(i - 1)}); end
        n_checks++; if ({n_out_valid, n_out_data} !== {1'b1, 128'(i - 1)}) begin n_fail++; $display("[TB] FAIL stream_single[%0d]: got %h expected %h", i, {n_out_valid, n_out_data}, {1'b1, 128'(i - 1)}); end
      end
      advance();
    end
    applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
    n_checks++; if (s_stall !== 16'd0) begin n_fail++; $display("[TB] FAIL stream_stall: got %0d expected 0", s_stall); end
    n_checks++; if ({s_out_valid, s_out_ctrl} !== 17'd0) begin n_fail++; $display("[TB] FAIL stream_empty: got %h expected 0", {s_out_valid, s_out_ctrl}); end
    advance();
  endtask

  task automatic test_backpressure();
    for (int t = 0; t < 9; t++) begin
      logic iv, ordy;
      iv   = (t < 6);
      ordy = (t < 2) || (t > 5);
      applyStimulus(iv, 128'h10 + 128'(t < 3 ? t : 3), 16'h0F0F, 1'b0, ordy);
      if (t == 2) begin
        n_checks++; if ({s_in_ready, s_occupancy, s_out_data} !== {1'b1, 2'd1, 128'h11}) begin n_fail++; $display("[TB] FAIL bp_absorb: got %h expected %h", {s_in_ready, s_occupancy, s_out_data}, {1'b1, 2'd1, 128'h11}); end
      end
      if (t >= 3 && t <= 6) begin
        n_checks++; if ({s_in_ready, s_occupancy, s_out_data, s_stall} !== {1'b0, 2'd2, 128'h11, 16'(t - 2)}) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", t, {s_in_ready, s_occupancy, s_out_data, s_stall}, {1'b0, 2'd2, 128'h11, 16'(t - 2)}); end
      end
      if (t == 7) begin
        n_checks++; if ({s_out_valid, s_in_ready, s_occupancy, s_out_data} !== {1'b1, 1'b1, 2'd1, 128'h12}) begin n_fail++; $display("[TB] FAIL bp_drain2: got %h expected %h", {s_out_valid, s_in_ready, s_occupancy, s_out_data}, {1'b1, 1'b1, 2'd1, 128'h12}); end
      end
      if (t == 8) begin
        n_checks++; if ({s_out_valid, s_occupancy} !== 3'd0) begin n_fail++; $display("[TB] FAIL bp_empty: got %h expected 0", {s_out_valid, s_occupancy}); end
      end
      n_checks++; if (n_obs !== exp_vec(1)) begin n_fail++; $display("[TB] FAIL bp_single[%0d]: got %h expected %h", t, n_obs, exp_vec(1)); end
      advance();
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 128'h20, 16'hFFFF, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b1, 128'h21, 16'hFFFF, 1'b0, 1'b0);
    n_checks++; if (s_out_data !== 128'h20) begin n_fail++; $display("[TB] FAIL flush_setup: got %h expected 20", s_out_data); end
    advance();
    applyStimulus(1'b1, 128'h22, 16'hFFFF, 1'b1, 1'b0);
    n_checks++; if ({s_occupancy, s_in_ready} !== {2'd2, 1'b0}) begin n_fail++; $display("[TB] FAIL flush_full: got %h expected %h", {s_occupancy, s_in_ready}, {2'd2, 1'b0}); end
    advance();
    applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
    n_checks++; if ({s_out_valid, s_out_ctrl, s_out_data, s_occupancy} !== 147'd0) begin n_fail++; $display("[TB] FAIL flush_clear_skid: got %h expected 0", {s_out_valid, s_out_ctrl, s_out_data, s_occupancy}); end
    n_checks++; if ({n_out_valid, n_out_ctrl, n_occupancy} !== 19'd0) begin n_fail++; $display("[TB] FAIL flush_clear_single: got %h expected 0", {n_out_valid, n_out_ctrl, n_occupancy}); end
    advance();
    applyStimulus(1'b1, 128'h23, 16'hFFFF, 1'b1, 1'b1);
    n_checks++; if ({s_in_ready, n_in_ready} !== 2'b11) begin n_fail++; $display("[TB] FAIL flush_ready: got %b expected 11", {s_in_ready, n_in_ready}); end
    advance();
    applyStimulus(1'b1, 128'h24, 16'hFFFF, 1'b0, 1'b1);
    n_checks++; if ({s_out_valid, n_out_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_discard: got %b expected 00", {s_out_valid, n_out_valid}); end
    advance();
    applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
    n_checks++; if ({s_out_data, n_out_data} !== {128'h24, 128'h24}) begin n_fail++; $display("[TB] FAIL flush_next: got %h/%h expected 24/24", s_out_data, n_out_data); end
    advance();
  endtask

  task automatic test_single();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 128'h30 + 128'(i), 16'h0001, 1'b0, 1'b1);
      n_checks++; if (n_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_tput_ready[%0d]: got %b expected 1", i, n_in_ready); end
      if (i > 0) begin
        n_checks++; if ({n_out_valid, n_out_data} !== {1'b1, 128'h30 + 128'(i - 1)}) begin n_fail++; $display("[TB] FAIL single_tput[%0d]: got %h expected %h", i, {n_out_valid, n_out_data}, {1'b1, 128'h30 + 128'(i - 1)}); end
      end
      advance();
    end
    applyStimulus(1'b1, 128'h40, 16'h0001, 1'b0, 1'b0);
    n_checks++; if ({n_in_ready, n_out_data} !== {1'b0, 128'h36}) begin n_fail++; $display("[TB] FAIL single_stall_ready: got %h expected %h", {n_in_ready, n_out_data}, {1'b0, 128'h36}); end
    advance();
    applyStimulus(1'b1, 128'h40, 16'h0001, 1'b0, 1'b1);
    n_checks++; if ({n_in_ready, n_out_data} !== {1'b1, 128'h36}) begin n_fail++; $display("[TB] FAIL single_resume: got %h expected %h", {n_in_ready, n_out_data}, {1'b1, 128'h36}); end
    advance();
    applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
    n_checks++; if (n_out_data !== 128'h40) begin n_fail++; $display("[TB] FAIL single_next: got %h expected 40", n_out_data); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom, $urandom},
                    16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
      n_checks++; if (s_obs !== exp_vec(0)) begin n_fail++; $display("[TB] FAIL random_skid[%0d]: got %h expected %h", i, s_obs, exp_vec(0)); end
      n_checks++; if (n_obs !== exp_vec(1)) begin n_fail++; $display("[TB] FAIL random_single[%0d]: got %h expected %h", i, n_obs, exp_vec(1)); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 128'h50, 16'h00FF, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b1, 128'h51, 16'h00FF, 1'b0, 1'b0);
    advance();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({s_out_valid, s_occupancy, s_out_data, s_out_ctrl, s_stall} !== 163'd0) begin n_fail++; $display("[TB] FAIL async_reset_skid: got %h expected 0", {s_out_valid, s_occupancy, s_out_data, s_out_ctrl, s_stall}); end
    n_checks++; if ({n_out_valid, n_occupancy, n_stall} !== 7'd0) begin n_fail++; $display("[TB] FAIL async_reset_single: got %h expected 0", {n_out_valid, n_occupancy, n_stall}); end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(1'b0, 128'd0, 16'd0, 1'b0, 1'b1);
      n_checks++; if (n_bubble !== 4'(i > 15 ? 15 : i)) begin n_fail++; $display("[TB] FAIL sat_bubble4[%0d]: got %0d expected %0d", i, n_bubble, (i > 15 ? 15 : i)); end
      n_checks++; if (s_bubble !== 16'(i)) begin n_fail++; $display("[TB] FAIL sat_bubble16[%0d]: got %0d expected %0d", i, s_bubble, i); end
      advance();
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b1;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_single();
    test_random();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_stage.md
# pipe_elastic_stage

Parametrised, elastic pipeline-stage register replacing the fixed-field stage registers between IF/ID/EXE/MEM/WB. Carries an opaque payload of DATA_W bits plus CTRL_W control bits. Uses a valid/ready handshake with an optional two-entry skid buffer, so backpressure no longer needs a global stall net. Supports synchronous flush (bubble insertion) and saturating stall and bubble counters for performance debug.

## Interface
- DATA_W, 128, payload width (pc4, operands, immediates, …).
- CTRL_W, 16, control width (write enables, mux selects, op/func).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous kill of all held and incoming beats.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of head entry; all-zero when out_valid=0.
- out_ctrl  out  CTRL_W  control of head entry; all-zero when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- bubble_cnt  out  CNT_W  cycles with !out_valid.

## Operation
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- SKID=1: entries main (head) and skid. in_ready = !skid_valid, registered. Accept with no drain: write main if empty, else write skid. Drain with skid_valid: skid moves to main, and any same-cycle accept lands in skid. Drain without skid_valid: main takes the accepted beat, or becomes empty.
- SKID=0: single entry; in_ready = !out_valid | out_ready (combinational). Accept and drain in the same cycle replaces the entry.
- Order is strictly preserved; no beat is duplicated or dropped except by flush.
- flush=1: next edge clears both valids and zeroes the data and ctrl of both entries. A beat offered in the flush cycle is discarded. in_ready is unaffected. A drain in the flush cycle still counts as delivered downstream.
- Bubble convention: invalid entries hold zeros, so out_ctrl has every enable low when the stage is empty.
- Counters saturate at all-ones and are cleared only by rst. Both are evaluated every cycle, including flush cycles.

## Timing
- Reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, bubble_cnt=0. in_ready=1 for SKID=1; for SKID=0 it follows its equation (=1 during reset).
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle with out_ready held high.
- SKID=1: after out_ready falls, one further beat is absorbed; in_ready falls at the following edge. After out_ready rises, in_ready returns one cycle after skid drains.
- Reset mid-transfer discards all entries immediately (asynchronous).
- Simultaneous flush and accept: flush wins.

## Structure
- Shared define header holds RST_ENABLED, WRITE_ENABLED, STOP and the new VALID/INVALID constants. No module-local magic values.
- One sub-module: pipe_sat_cnt (CNT_W-bit saturating counter with increment enable), instantiated twice.
- The SKID generate branch lives in this module; no further hierarchy.

## Test plan
- Reset with in_valid=1 and in_data=0xA5…: all outputs zero while rst=1. First accept after release gives out_valid at the next edge, with out_data=0xA5….
- Streaming with SKID=1 and out_ready=1: 8 beats of 0..7 emerge in order at 1/cycle, occupancy stays 1, stall_cnt=0.
- Backpressure with SKID=1: drop out_ready while streaming. Exactly one extra beat is accepted (occupancy=2), in_ready falls next cycle, and stall_cnt increments once per held cycle. Raising out_ready drains both beats in order.
- Flush with occupancy=2 and in_valid=1: next cycle out_valid=0, out_ctrl=0, occupancy=0, and the offered beat never appears downstream.
- SKID=0 with simultaneous accept and drain every cycle: 100% throughput. With out_ready=0, in_ready=0 in the same cycle.
- Counter saturation with CNT_W=4: 20 idle cycles leave bubble_cnt=15, and it stays at 15.
